// File: rtl/frame_buffer_matrix3_controller.sv
// Write/read sequencer for the 3x3 frame buffer: stores raster rows into the circular
// row store, then sweeps each completed centre row and tags the buffer's matrix output.
module frame_buffer_matrix3_controller #(
    parameter int unsigned P_COLUMNS         = 640,
    parameter int unsigned P_ROWS            = 4,
    parameter int unsigned P_FRAME_ROWS      = 480,
    parameter int unsigned P_PIXEL_DEPTH     = 8,
    parameter int unsigned P_COLUMNS_BITS    = $clog2(P_COLUMNS),
    parameter int unsigned P_ROWS_BITS       = $clog2(P_ROWS),
    parameter int unsigned P_FRAME_ROWS_BITS = $clog2(P_FRAME_ROWS)
) (
    input  logic                         I_CLK,
    input  logic                         I_RESET,
    input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
    input  logic                         I_PIXEL_VALID,
    output logic                         O_PIXEL_READY,
    output logic [P_COLUMNS_BITS-1:0]    O_BUF_COLUMN,
    output logic [P_ROWS_BITS-1:0]       O_BUF_ROW,
    output logic [P_PIXEL_DEPTH-1:0]     O_BUF_PIXEL,
    output logic                         O_BUF_WRITE_ENABLE,
    output logic                         O_BUF_READ_ENABLE,
    output logic                         O_MATRIX_VALID,
    output logic [P_COLUMNS_BITS-1:0]    O_MATRIX_COLUMN,
    output logic [P_FRAME_ROWS_BITS-1:0] O_MATRIX_ROW,
    output logic                         O_FRAME_DONE
);

    localparam logic [P_COLUMNS_BITS-1:0]    L_COL_LAST    = P_COLUMNS_BITS'(P_COLUMNS - 1);
    localparam logic [P_ROWS_BITS-1:0]       L_ROW_LAST    = P_ROWS_BITS'(P_ROWS - 1);
    localparam logic [P_FRAME_ROWS_BITS-1:0] L_CENTRE_LAST = P_FRAME_ROWS_BITS'(P_FRAME_ROWS - 2);
    localparam logic [P_FRAME_ROWS_BITS-1:0] L_FIRST_READ  = P_FRAME_ROWS_BITS'(2);

    typedef enum logic [0:0] {
        S_WRITE,
        S_READ
    } state_t;

    state_t                         state_q, state_d;
    logic [P_COLUMNS_BITS-1:0]      col_q, col_d;
    logic [P_ROWS_BITS-1:0]         wr_row_q, wr_row_d;
    logic [P_ROWS_BITS-1:0]         rd_row_q, rd_row_d;
    logic [P_FRAME_ROWS_BITS-1:0]   img_row_q, img_row_d;
    logic [P_FRAME_ROWS_BITS-1:0]   centre_q, centre_d;

    logic                           matrix_valid_q;
    logic [P_COLUMNS_BITS-1:0]      matrix_col_q;
    logic [P_FRAME_ROWS_BITS-1:0]   matrix_row_q;
    logic                           frame_done_q, frame_done_d;

    logic                           read_en;
    logic                           write_en;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q   <= S_WRITE;
            col_q     <= '0;
            wr_row_q  <= '0;
            rd_row_q  <= '0;
            img_row_q <= '0;
            centre_q  <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            wr_row_q  <= wr_row_d;
            rd_row_q  <= rd_row_d;
            img_row_q <= img_row_d;
            centre_q  <= centre_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        wr_row_d     = wr_row_q;
        rd_row_d     = rd_row_q;
        img_row_d    = img_row_q;
        centre_d     = centre_q;
        read_en      = 1'b0;
        write_en     = 1'b0;
        frame_done_d = 1'b0;
        O_BUF_ROW    = wr_row_q;

        unique case (state_q)
            S_WRITE: begin
                write_en  = I_PIXEL_VALID;
                O_BUF_ROW = wr_row_q;
                if (I_PIXEL_VALID) begin
                    if (col_q == L_COL_LAST) begin
                        col_d     = '0;
                        wr_row_d  = (wr_row_q == L_ROW_LAST) ? '0 : wr_row_q + 1'b1;
                        img_row_d = img_row_q + 1'b1;
                        // Completed row r gives both neighbours of centre r-1.
                        if (img_row_q >= L_FIRST_READ) begin
                            state_d  = S_READ;
                            rd_row_d = (wr_row_q == '0) ? L_ROW_LAST : wr_row_q - 1'b1;
                            centre_d = img_row_q - 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_READ: begin
                read_en   = 1'b1;
                O_BUF_ROW = rd_row_q;
                if (col_q == L_COL_LAST) begin
                    col_d   = '0;
                    state_d = S_WRITE;
                    if (centre_q == L_CENTRE_LAST) begin
                        frame_done_d = 1'b1;
                        img_row_d    = '0;
                        wr_row_d     = '0;
                        rd_row_d     = '0;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WRITE;
            end
        endcase
    end

    // Sideband lines up with the buffer's one-cycle registered matrix output.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            matrix_valid_q <= 1'b0;
            matrix_col_q   <= '0;
            matrix_row_q   <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            matrix_valid_q <= read_en;
            frame_done_q   <= frame_done_d;
            if (read_en) begin
                matrix_col_q <= col_q;
                matrix_row_q <= centre_q;
            end
        end
    end

    assign O_PIXEL_READY      = (state_q == S_WRITE);
    assign O_BUF_COLUMN       = col_q;
    assign O_BUF_PIXEL        = I_PIXEL;
    assign O_BUF_WRITE_ENABLE = write_en;
    assign O_BUF_READ_ENABLE  = read_en;
    assign O_MATRIX_VALID     = matrix_valid_q;
    assign O_MATRIX_COLUMN    = matrix_col_q;
    assign O_MATRIX_ROW       = matrix_row_q;
    assign O_FRAME_DONE       = frame_done_q;

endmodule

// File: tb/tb_frame_buffer_matrix3_controller.sv
// Randomised bench for frame_buffer_matrix3_controller against a pixel-count reference model.
module tb_frame_buffer_matrix3_controller;

    localparam int C  = 4;
    localparam int R  = 4;
    localparam int F  = 5;
    localparam int PD = 8;
    localparam int CB = $clog2(C);
    localparam int RB = $clog2(R);
    localparam int FB = $clog2(F);

    logic          I_CLK = 1'b0;
    logic          I_RESET;
    logic [PD-1:0] I_PIXEL;
    logic          I_PIXEL_VALID;
    logic          O_PIXEL_READY;
    logic [CB-1:0] O_BUF_COLUMN;
    logic [RB-1:0] O_BUF_ROW;
    logic [PD-1:0] O_BUF_PIXEL;
    logic          O_BUF_WRITE_ENABLE;
    logic          O_BUF_READ_ENABLE;
    logic          O_MATRIX_VALID;
    logic [CB-1:0] O_MATRIX_COLUMN;
    logic [FB-1:0] O_MATRIX_ROW;
    logic          O_FRAME_DONE;

    frame_buffer_matrix3_controller #(
        .P_COLUMNS     (C),
        .P_ROWS        (R),
        .P_FRAME_ROWS  (F),
        .P_PIXEL_DEPTH (PD)
    ) dut (
        .I_CLK              (I_CLK),
        .I_RESET            (I_RESET),
        .I_PIXEL            (I_PIXEL),
        .I_PIXEL_VALID      (I_PIXEL_VALID),
        .O_PIXEL_READY      (O_PIXEL_READY),
        .O_BUF_COLUMN       (O_BUF_COLUMN),
        .O_BUF_ROW          (O_BUF_ROW),
        .O_BUF_PIXEL        (O_BUF_PIXEL),
        .O_BUF_WRITE_ENABLE (O_BUF_WRITE_ENABLE),
        .O_BUF_READ_ENABLE  (O_BUF_READ_ENABLE),
        .O_MATRIX_VALID     (O_MATRIX_VALID),
        .O_MATRIX_COLUMN    (O_MATRIX_COLUMN),
        .O_MATRIX_ROW       (O_MATRIX_ROW),
        .O_FRAME_DONE       (O_FRAME_DONE)
    );

    always #5 I_CLK = ~I_CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pixels accepted this frame and the pending read pass.
    int m_n      = 0;
    int m_left   = 0;
    int m_centre = 0;
    int m_sv_valid = 0;
    int m_sv_col   = 0;
    int m_sv_row   = 0;
    int m_sv_done  = 0;
    int exp_done_count = 0;
    int dut_done_count = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_left = 0; m_centre = 0;
        m_sv_valid = 0; m_sv_col = 0; m_sv_row = 0; m_sv_done = 0;
    endtask

    task automatic step(input logic rst, input logic vld, input logic [PD-1:0] pix);
        int exp_read;
        I_RESET       = rst;
        I_PIXEL_VALID = vld;
        I_PIXEL       = pix;
        @(negedge I_CLK);
        exp_read = (m_left > 0) ? 1 : 0;
        check("ready", int'(O_PIXEL_READY), 1 - exp_read);
        check("rd_en", int'(O_BUF_READ_ENABLE), exp_read);
        check("wr_en", int'(O_BUF_WRITE_ENABLE), (exp_read == 0 && vld) ? 1 : 0);
        if (exp_read != 0) begin
            check("rd_row", int'(O_BUF_ROW), m_centre % R);
            check("rd_col", int'(O_BUF_COLUMN), C - m_left);
        end else begin
            check("wr_row", int'(O_BUF_ROW), (m_n / C) % R);
            check("wr_col", int'(O_BUF_COLUMN), m_n % C);
            if (vld) check("wr_pixel", int'(O_BUF_PIXEL), int'(pix));
        end
        check("m_valid", int'(O_MATRIX_VALID), m_sv_valid);
        check("frame_done", int'(O_FRAME_DONE), m_sv_done);
        if (m_sv_valid != 0) begin
            check("m_col", int'(O_MATRIX_COLUMN), m_sv_col);
            check("m_row", int'(O_MATRIX_ROW), m_sv_row);
        end
        if (O_FRAME_DONE) dut_done_count++;
        @(posedge I_CLK);
        if (rst) begin
            model_reset();
        end else begin
            m_sv_valid = exp_read;
            m_sv_col   = C - m_left;
            m_sv_row   = m_centre;
            m_sv_done  = (exp_read != 0 && m_left == 1 && m_centre == F - 2) ? 1 : 0;
            if (m_sv_done != 0) exp_done_count++;
            if (exp_read != 0) begin
                m_left--;
                if (m_left == 0 && m_centre == F - 2) m_n = 0;
            end else if (vld) begin
                m_n++;
                if (m_n % C == 0 && (m_n / C - 1) >= 2) begin
                    m_left   = C;
                    m_centre = m_n / C - 2;
                end
            end
        end
        #1;
    endtask

    initial begin
        bit found;
        I_RESET = 1'b1; I_PIXEL_VALID = 1'b0; I_PIXEL = '0;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        // Pixels 1..12 then the first read pass.
        for (int p = 1; p <= 12; p++) step(1'b0, 1'b1, PD'(p));
        for (int i = 0; i < C + 2; i++) step(1'b0, 1'(i % 2), PD'($urandom));

        // Alternating valid.
        for (int i = 0; i < 40; i++) step(1'b0, 1'(i % 2), PD'($urandom));

        // Random valid over several frames, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), PD'($urandom));
        end

        // Reset on the second cycle of a read pass.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_left == C - 1) found = 1'b1;
            else step(1'b0, 1'b1, PD'($urandom));
        end
        check("reach_read_pass", int'(found), 1);
        step(1'b1, 1'b1, PD'($urandom));
        step(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, PD'($urandom));

        check("frame_done_count", dut_done_count, exp_done_count);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
